burst_trap_decoder_seq: RTL
===========================

Name: burst_trap_decoder_seq

Overview:
- Sequential error-trapping decoder for the team's cyclic (31,16) burst-correcting code.
- Accepts a 31-bit systematic codeword on a valid/ready handshake and computes the syndrome serially with an LFSR divider.
- Cyclically shifts the syndrome until a burst of length at most B is trapped, then corrects the buffered codeword and presents the 16-bit message on an output valid/ready handshake.
- Multi-cycle, low-area counterpart to the combinational encoder path; it sits on the receive side of the link.

Parameters:
- N, 31, codeword length (fixed; only default supported).
- K, 16, message length (fixed; N-K = 15 = syndrome width).
- B, 7, maximum correctable burst length; the trap condition checks the upper N-K-B = 8 syndrome stages.
- G_POLY, 15'h0FAF, generator g(x) coefficients x^14..x^0 with the x^15 term implicit (octal 107657 including x^15).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- cw_in  in  [0:30]  codeword; bit 0 = coefficient of x^30; message is bits [0:15], parity is bits [16:30].
- cw_valid  in  1  cw_in is valid.
- cw_ready  out  1  decoder can accept; high only in IDLE.
- msg_out  out  [0:15]  corrected message.
- msg_valid  out  1  msg_out and status flags are valid.
- msg_ready  in  1  downstream accepts msg_out.
- corrected  out  1  nonzero burst found and flipped.
- uncorrectable  out  1  no trap found in 31 shifts.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - msg_out=0, msg_valid=0, corrected=0, uncorrectable=0.
  - Syndrome register, shift counter and codeword buffer are cleared.
  - rst overrides every other input, in any state including mid-SYND or mid-TRAP. The word in flight is discarded.
- cw_ready: cw_ready = (state==IDLE); it is 0 in every other state.
- IDLE:
  - On cw_valid & cw_ready, latch cw_in into the buffer and go to SYND. Call this edge cycle 0.
  - cw_in is ignored at all other times.
- SYND, 31 cycles (cycles 1..31):
  - Shift buffer bits 0..30 one per cycle, MSB first, into the 15-bit divider: s = (s<<1 | bit) with XOR of G_POLY when the outgoing s[14]=1.
  - The final value is c(x) mod g(x).
- TRAP, check i = 0..30, one per cycle, starting at cycle 32:
  - If s[14:7]==0, the burst is trapped: record i and pattern b = s[6:0], then go to FIX.
  - Otherwise s <= x*s mod g and i++.
  - If i=30 fails, set the no-trap flag and go to FIX.
  - A zero syndrome traps at i=0 with b=0.
- FIX, 1 cycle:
  - Error polynomial e(x) = x^j·b(x) with j = (31-i) mod 31; exponents wrap mod 31, so cyclic wrap-around bursts are allowed.
  - Flip the buffer bit at index 30-((j+k) mod 31) for each set b[k].
  - Load msg_out = buffer[0:15] after flipping.
  - corrected = (b!=0) & trapped; uncorrectable = !trapped.
  - When uncorrectable, no bits are flipped and the raw message is output.
  - Go to OUT.
- OUT:
  - msg_valid=1; msg_out and the flags are held stable while msg_ready=0.
  - On msg_valid & msg_ready, msg_valid goes to 0 next cycle and the state returns to IDLE, so cw_ready=1 in the following cycle.
  - There is no overlap between successive words.
- Latency:
  - Trap at index i: msg_valid first high at cycle 34+i; error-free words take 34 cycles.
  - Uncorrectable: msg_valid first high at cycle 64.
- Counters: i is a 5-bit counter that saturates at 30; it is never compared beyond 30.
- Parity errors: the correction is applied to the full buffer, but only bits [0:15] are output. A burst confined to parity bits yields corrected=1 with an unchanged message.

Test Plan:
- Error-free: msg 16'hFFFF encoded by the software model (same G_POLY), cw_valid for 1 cycle -> msg_out=16'hFFFF, corrected=0, uncorrectable=0, msg_valid at cycle 34.
- Single flip of cw_in[0] on the FFFF codeword -> msg_out=16'hFFFF, corrected=1, latency 34+i with i matching the model.
- Wrap-around 3-bit burst flipping cw_in[29], [30], [0] -> msg_out=16'hFFFF, corrected=1.
- Exhaustive sweep: 25 start positions × 128 7-bit patterns, plus wrap positions, on the FFFF codeword -> msg_out, corrected, uncorrectable and latency must match the model for every case. Any case where the model reports no trap must give uncorrectable=1, the raw message bits, and msg_valid at cycle 64.
- Backpressure: hold msg_ready=0 for 10 cycles in OUT -> msg_out and flags stable, cw_ready=0 throughout. Then raise msg_ready -> msg_valid=0 next cycle, cw_ready=1 the cycle after.
- Reset mid-TRAP: assert rst at cycle 40 -> next cycle state IDLE, msg_valid=0, all flags 0, cw_ready=1. A subsequent clean word decodes normally with 34-cycle latency.

Source files
------------

// File: rtl/burst_trap_decoder_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// burst_trap_decoder_seq_if : codeword-in / message-out handshake bundle
// Rev 1.0
// =============================================================================
interface burst_trap_decoder_seq_if;
  logic [0:30] cw_in;
  logic        cw_valid;
  logic        cw_ready;
  logic [0:15] msg_out;
  logic        msg_valid;
  logic        msg_ready;
  logic        corrected;
  logic        uncorrectable;

  modport master (
    output cw_in, cw_valid, msg_ready,
    input  cw_ready, msg_out, msg_valid, corrected, uncorrectable
  );

  modport slave (
    input  cw_in, cw_valid, msg_ready,
    output cw_ready, msg_out, msg_valid, corrected, uncorrectable
  );
endinterface
`default_nettype wire

// File: rtl/burst_trap_decoder_seq.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// burst_trap_decoder_seq : serial error-trapping decoder, cyclic (31,16) burst code
// Rev 1.0
// =============================================================================
module burst_trap_decoder_seq #(
  parameter int          N      = 31,
  parameter int          K      = 16,
  parameter int          B      = 7,
  parameter logic [14:0] G_POLY = 15'h0FAF
) (
  input  logic                     clk,
  input  logic                     rst,
  burst_trap_decoder_seq_if.slave  bus
);

  localparam int P = N - K;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYND = 3'd1;
  localparam logic [2:0] S_TRAP = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [4:0] LAST = 5'(N - 1);

  logic [2:0]   state_q,   state_d;
  logic [N-1:0] buf_q,     buf_d;     // bit position == polynomial exponent
  logic [P-1:0] syn_q,     syn_d;
  logic [4:0]   cnt_q,     cnt_d;
  logic [B-1:0] pat_q,     pat_d;
  logic         trapped_q, trapped_d;
  logic [K-1:0] msg_q,     msg_d;
  logic         valid_q,   valid_d;
  logic         corr_q,    corr_d;
  logic         unc_q,     unc_d;

  logic [4:0]     bit_idx;
  logic [4:0]     shift_j;
  logic [2*N-1:0] rot_w;
  logic [N-1:0]   mask_w;
  logic [N-1:0]   fixed_w;

  assign bit_idx = LAST - cnt_q;
  assign shift_j = (cnt_q == 5'd0) ? 5'd0 : 5'(N) - cnt_q;

  // Cyclic rotation of the trapped pattern by j, wrapping exponents mod N
  assign rot_w   = {{(2*N-B){1'b0}}, pat_q} << shift_j;
  assign mask_w  = rot_w[N-1:0] | rot_w[2*N-1:N];
  assign fixed_w = trapped_q ? (buf_q ^ mask_w) : buf_q;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    syn_d     = syn_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    trapped_d = trapped_q;
    msg_d     = msg_q;
    valid_d   = valid_q;
    corr_d    = corr_q;
    unc_d     = unc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cw_valid) begin
          buf_d     = bus.cw_in;
          syn_d     = '0;
          cnt_d     = '0;
          pat_d     = '0;
          trapped_d = 1'b0;
          state_d   = S_SYND;
        end
      end
      S_SYND: begin
        syn_d = {syn_q[P-2:0], buf_q[bit_idx]} ^ (syn_q[P-1] ? G_POLY : '0);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_TRAP: begin
        if (syn_q[P-1:B] == '0) begin
          pat_d     = syn_q[B-1:0];
          trapped_d = 1'b1;
          state_d   = S_FIX;
        end else if (cnt_q == LAST) begin
          trapped_d = 1'b0;
          state_d   = S_FIX;
        end else begin
          syn_d = {syn_q[P-2:0], 1'b0} ^ (syn_q[P-1] ? G_POLY : '0);
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_FIX: begin
        msg_d   = fixed_w[N-1:N-K];
        corr_d  = trapped_q & (|pat_q);
        unc_d   = ~trapped_q;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.msg_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      syn_q     <= '0;
      cnt_q     <= '0;
      pat_q     <= '0;
      trapped_q <= 1'b0;
      msg_q     <= '0;
      valid_q   <= 1'b0;
      corr_q    <= 1'b0;
      unc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      syn_q     <= syn_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      trapped_q <= trapped_d;
      msg_q     <= msg_d;
      valid_q   <= valid_d;
      corr_q    <= corr_d;
      unc_q     <= unc_d;
    end
  end

  assign bus.cw_ready      = (state_q == S_IDLE);
  assign bus.msg_out       = msg_q;
  assign bus.msg_valid     = valid_q;
  assign bus.corrected     = corr_q;
  assign bus.uncorrectable = unc_q;

endmodule
`default_nettype wire
